shift_cipher_lane_pipe: RTL and testbench
=========================================

Name: shift_cipher_lane_pipe

Overview:
- Parametrised successor to the single-byte decrypt shift stage.
- Performs Caesar shift encryption or decryption on LANES bytes per beat. Letters (A-Z, a-z) are rotated modulo 26; all other bytes pass through unchanged.
- Two-stage registered pipeline with a valid/ready handshake and full backpressure.
- Sits between the byte packer and the output framer of the encrypter/decrypter datapath.

Parameters:
- LANES, 4, number of byte lanes processed per beat (1..16).
- SHIFT_W, 5, width of shift_amt (5..8); values are reduced modulo 26.
- CNT_W, 16, width of the accepted-beat counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_data  in  8*LANES  input bytes; lane i is bits [8i+7:8i].
- in_lane_en  in  LANES  per-lane enable; a disabled lane passes its byte unchanged.
- shift_amt  in  SHIFT_W  shift key, sampled with the beat.
- mode  in  1  0 = encrypt (add shift), 1 = decrypt (subtract shift); sampled with the beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  8*LANES  transformed bytes.
- beat_cnt  out  CNT_W  count of beats accepted at the input.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, beat_cnt=0, all pipeline stage valids=0, in_ready=1 once the internal valids are 0. Asserting rst mid-stream discards every in-flight beat.
- Accept: a beat transfers at a rising edge when in_valid && in_ready. Output transfers when out_valid && out_ready.
- Stage 1 registers, per lane:
  - the byte;
  - its class: UPPER (65..90), LOWER (97..122) or OTHER;
  - the letter index (byte minus 65 or minus 97, 0..25);
  - keff = shift_amt mod 26, computed by repeated conditional subtract of 26 (correct for any SHIFT_W up to 8);
  - mode and the lane-enable bit.
- Stage 2 computes, per lane:
  - encrypt: r = idx + keff; if r >= 26 then r -= 26.
  - decrypt: r = idx - keff; if r < 0 then r += 26.
  - Output byte = base + r, where base is 65 (UPPER) or 97 (LOWER).
  - OTHER-class bytes and disabled lanes pass through unchanged.
  - The result registers into out_data.
- Latency: exactly 2 cycles from input accept to out_valid with no backpressure. Throughput is 1 beat per cycle.
- Handshake:
  - s2 may load when !s2_valid || out_ready.
  - s1 advances into s2 when s1_valid && (s2 may load).
  - in_ready = !s1_valid || (s1 advances).
  - The ready path is combinational from out_ready. No beat is dropped or duplicated.
  - out_data is held stable while out_valid && !out_ready.
- Simultaneous load and unload of a stage in the same cycle is legal; it neither bubbles nor stalls.
- beat_cnt increments by 1 per input accept and wraps from 2^CNT_W-1 to 0.
- Key boundaries:
  - keff=0 means identity.
  - shift_amt=26 behaves as 0; shift_amt=27 behaves as 1.
  - Wrap-around: 'Z' encrypt 1 gives 'A'; 'a' decrypt 1 gives 'z'.
- Case is preserved. Non-letter bytes, including '@' (64), '[' (91), '`' (96) and '{' (123), are never altered.

Optional Feature:
- Macro: SHIFT_CIPHER_ROLLING_KEY_EN.
- With the macro defined:
  - The block holds a key offset register koff (0..25, reset 0).
  - Each lane's effective key is (keff + koff + i) mod 26, where i is the lane index.
  - koff advances by LANES mod 26 on every input accept, giving a progressive per-character key.
  - Encrypt and decrypt streams stay aligned provided both ends see the same beat sequence since reset.
- Without the macro: the key is static per beat (keff only), no koff register exists, and behaviour is exactly as above.

Test Plan:
- Reset/idle: rst pulse mid-stream with 2 beats in flight -> out_valid=0 next cycle, beat_cnt=0, in_ready=1, no stale beat emerges afterwards.
- Basic encrypt: LANES=4, in_data="AZaz" (0x7A61_5A41), shift_amt=3, mode=0, all lanes enabled -> 2 cycles later out_data="DCdc" (0x6364_4344).
- Decrypt and wrap: in_data="DCdc", shift_amt=3, mode=1 -> "AZaz". Separately "a1{@" with shift_amt=1, mode=1 -> "z1{@", with non-letters unchanged.
- Key modulo and lane enable: shift_amt=29, mode=0, in_data="abcd", in_lane_en=4'b0101 -> "dbfd" (lanes 0 and 2 shifted by 3; lanes 1 and 3 passed through).
- Backpressure: stream 8 back-to-back beats with a random out_ready pattern (e.g. 1011_0010...) -> all 8 beats out in order, out_data stable while stalled, beat_cnt=8, no beat lost or duplicated.
- Rolling key (macro on): two beats of "aaaa" with shift_amt=0, mode=0 -> "abcd", then "efgh". Decrypting the same sequence after reset restores "aaaa" twice.

Source files
------------

// File: rtl/shift_cipher_lane_pipe.sv
// Two-stage Caesar shift pipeline over LANES byte lanes with valid/ready backpressure.
// Optional SHIFT_CIPHER_ROLLING_KEY_EN adds a per-lane, per-beat progressive key offset.
module shift_cipher_lane_pipe #(
    parameter int LANES   = 4,
    parameter int SHIFT_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic [LANES-1:0]     in_lane_en,
    input  logic [SHIFT_W-1:0]   shift_amt,
    input  logic                 mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic [CNT_W-1:0]     beat_cnt
);

    localparam logic [1:0] CLS_OTHER = 2'd0;
    localparam logic [1:0] CLS_UPPER = 2'd1;
    localparam logic [1:0] CLS_LOWER = 2'd2;

    logic               r_s1_valid;
    logic               r_s2_valid;
    logic [7:0]         r_s1_byte [LANES];
    logic [1:0]         r_s1_cls  [LANES];
    logic [4:0]         r_s1_idx  [LANES];
    logic [4:0]         r_s1_key  [LANES];
    logic               r_s1_mode;
    logic [LANES-1:0]   r_s1_en;
    logic [8*LANES-1:0] r_out_data;
    logic [CNT_W-1:0]   r_beat_cnt;

    logic [7:0]         w_byte [LANES];
    logic [1:0]         w_cls  [LANES];
    logic [4:0]         w_idx  [LANES];
    logic [4:0]         w_key  [LANES];
    logic [4:0]         w_keff;
    logic [8*LANES-1:0] w_out_word;
    logic               w_s2_load_ok;
    logic               w_s1_adv;
    logic               w_in_fire;

    // Nine subtractions cover the largest 8-bit key (255 = 9*26 + 21).
    function automatic logic [4:0] mod26(input logic [SHIFT_W-1:0] v);
        logic [8:0] t;
        t = '0;
        t[SHIFT_W-1:0] = v;
        for (int k = 0; k < 10; k++) begin
            if (t >= 9'd26) t = t - 9'd26;
        end
        return 5'(t);
    endfunction

    function automatic logic [7:0] xform(input logic [7:0] b, input logic [1:0] cls,
                                         input logic [4:0] idx, input logic [4:0] key,
                                         input logic dec, input logic en);
        logic [5:0] r;
        logic [7:0] base;
        if (!en || cls == CLS_OTHER) return b;
        base = (cls == CLS_UPPER) ? 8'd65 : 8'd97;
        if (!dec) begin
            r = {1'b0, idx} + {1'b0, key};
            if (r >= 6'd26) r = r - 6'd26;
        end else begin
            r = {1'b0, idx} - {1'b0, key};
            if (idx < key) r = r + 6'd26;
        end
        return base + 8'(r);
    endfunction

`ifdef SHIFT_CIPHER_ROLLING_KEY_EN
    localparam logic [4:0] KOFF_STEP = 5'(LANES % 26);
    logic [4:0] r_koff;

    function automatic logic [4:0] lane_key(input logic [4:0] k, input logic [4:0] o, input int lane);
        logic [6:0] s;
        s = 7'(k) + 7'(o) + 7'(lane);
        if (s >= 7'd26) s = s - 7'd26;
        if (s >= 7'd26) s = s - 7'd26;
        return 5'(s);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_koff <= '0;
        end else if (w_in_fire) begin
            r_koff <= lane_key(r_koff, KOFF_STEP, 0);
        end
    end
`endif

    assign w_s2_load_ok = !r_s2_valid || out_ready;
    assign w_s1_adv     = r_s1_valid && w_s2_load_ok;
    assign in_ready     = !r_s1_valid || w_s1_adv;
    assign w_in_fire    = in_valid && in_ready;
    assign out_valid    = r_s2_valid;
    assign out_data     = r_out_data;
    assign beat_cnt     = r_beat_cnt;

    always_comb begin
        w_keff = mod26(shift_amt);
        for (int i = 0; i < LANES; i++) begin
            w_byte[i] = in_data[8*i +: 8];
            w_cls[i]  = CLS_OTHER;
            w_idx[i]  = '0;
            if (w_byte[i] >= 8'd65 && w_byte[i] <= 8'd90) begin
                w_cls[i] = CLS_UPPER;
                w_idx[i] = 5'(w_byte[i] - 8'd65);
            end else if (w_byte[i] >= 8'd97 && w_byte[i] <= 8'd122) begin
                w_cls[i] = CLS_LOWER;
                w_idx[i] = 5'(w_byte[i] - 8'd97);
            end
`ifdef SHIFT_CIPHER_ROLLING_KEY_EN
            w_key[i] = lane_key(w_keff, r_koff, i);
`else
            w_key[i] = w_keff;
`endif
        end
    end

    always_comb begin
        w_out_word = '0;
        for (int i = 0; i < LANES; i++) begin
            w_out_word[8*i +: 8] = xform(r_s1_byte[i], r_s1_cls[i], r_s1_idx[i],
                                         r_s1_key[i], r_s1_mode, r_s1_en[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s1_mode  <= 1'b0;
            r_s1_en    <= '0;
            r_out_data <= '0;
            r_beat_cnt <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_s1_byte[i] <= '0;
                r_s1_cls[i]  <= CLS_OTHER;
                r_s1_idx[i]  <= '0;
                r_s1_key[i]  <= '0;
            end
        end else begin
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
                r_s1_mode  <= mode;
                r_s1_en    <= in_lane_en;
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                for (int i = 0; i < LANES; i++) begin
                    r_s1_byte[i] <= w_byte[i];
                    r_s1_cls[i]  <= w_cls[i];
                    r_s1_idx[i]  <= w_idx[i];
                    r_s1_key[i]  <= w_key[i];
                end
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
            // out_data only moves when s2 may load, which holds it during a stall.
            if (w_s2_load_ok) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) r_out_data <= w_out_word;
            end
        end
    end

endmodule

// File: tb/tb_shift_cipher_lane_pipe.sv
// Directed self-checking bench for shift_cipher_lane_pipe (LANES=4).
module tb_shift_cipher_lane_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_lane_en;
    logic [4:0]  shift_amt;
    logic        mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [15:0] beat_cnt;

    int checks   = 0;
    int failures = 0;

    shift_cipher_lane_pipe #(.LANES(4), .SHIFT_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_lane_en(in_lane_en), .shift_amt(shift_amt), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_byte(input logic [7:0] b, input int sh, input bit dec, input bit en);
        int k, base, idx, r;
        k = sh % 26;
        if (!en) return b;
        if (b >= 8'd65 && b <= 8'd90) base = 65;
        else if (b >= 8'd97 && b <= 8'd122) base = 97;
        else return b;
        idx = int'(b) - base;
        r = dec ? (idx - k + 26) % 26 : (idx + k) % 26;
        return 8'(base + r);
    endfunction

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] en, input logic [4:0] sh,
                             input logic md, output logic [31:0] q, output int lat);
        in_valid = 1'b1; in_data = d; in_lane_en = en; shift_amt = sh; mode = md; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        q = out_data;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_lane_en = 4'hF; shift_amt = '0; mode = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (beat_cnt !== 16'h0) begin failures++; $display("FAIL reset_beat_cnt got=%0d exp=0", beat_cnt); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        rst = 1'b0;
    endtask

    task automatic test_midstream_reset();
        int stale;
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h44434241; in_lane_en = 4'hF; shift_amt = 5'd1; mode = 1'b0;
        @(posedge clk); #1;
        in_data = 32'h48474645;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (beat_cnt !== 16'd2) begin failures++; $display("FAIL mid_cnt_before got=%0d exp=2", beat_cnt); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
        checks++; if (beat_cnt !== 16'd0) begin failures++; $display("FAIL mid_beat_cnt got=%0d exp=0", beat_cnt); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        checks++; if (stale !== 0) begin failures++; $display("FAIL mid_stale_beats got=%0d exp=0", stale); end
    endtask

    task automatic test_encrypt();
        logic [31:0] q; int lat;
        do_reset();
        send_beat(32'h7A615A41, 4'hF, 5'd3, 1'b0, q, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL enc_latency got=%0d exp=2", lat); end
        checks++; if (q !== 32'h63644344) begin failures++; $display("FAIL enc_AZaz got=%h exp=63644344", q); end
        send_beat(32'h7A615A41, 4'hF, 5'd0, 1'b0, q, lat);
        checks++; if (q !== 32'h7A615A41) begin failures++; $display("FAIL enc_identity got=%h exp=7a615a41", q); end
    endtask

    task automatic test_decrypt();
        logic [31:0] q; int lat;
        send_beat(32'h63644344, 4'hF, 5'd3, 1'b1, q, lat);
        checks++; if (q !== 32'h7A615A41) begin failures++; $display("FAIL dec_DCdc got=%h exp=7a615a41", q); end
        send_beat(32'h407B3161, 4'hF, 5'd1, 1'b1, q, lat);
        checks++; if (q !== 32'h407B317A) begin failures++; $display("FAIL dec_wrap got=%h exp=407b317a", q); end
    endtask

    task automatic test_key_boundary();
        logic [31:0] q; int lat;
        send_beat(32'h7B60617A, 4'hF, 5'd29, 1'b0, q, lat);
        checks++; if (q !== 32'h7B606463) begin failures++; $display("FAIL key29_enc got=%h exp=7b606463", q); end
        send_beat(32'h5B407A5A, 4'hF, 5'd26, 1'b0, q, lat);
        checks++; if (q !== 32'h5B407A5A) begin failures++; $display("FAIL key26_identity got=%h exp=5b407a5a", q); end
        send_beat(32'h5B407A5A, 4'hF, 5'd27, 1'b0, q, lat);
        checks++; if (q !== 32'h5B406141) begin failures++; $display("FAIL key27_wrap got=%h exp=5b406141", q); end
    endtask

    task automatic test_lane_enable();
        logic [31:0] q; int lat;
        send_beat(32'h64636261, 4'b0101, 5'd29, 1'b0, q, lat);
        checks++; if (q !== 32'h64666264) begin failures++; $display("FAIL lane_en got=%h exp=64666264", q); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] bp_d [8];
        logic [4:0]  bp_s [8];
        logic        bp_m [8];
        logic [31:0] exp_q [8];
        logic [15:0] pattern;
        logic [31:0] hold_d;
        logic        held, fire_in;
        int tx, rx, extra;
        pattern = 16'b1011_0010_0110_1101;
        for (int k = 0; k < 8; k++) begin
            bp_d[k] = {8'(8'h30 + k), 8'(8'h7A - k), 8'(8'h41 + k), 8'(8'h61 + k)};
            bp_s[k] = 5'(k * 4 + 3);
            bp_m[k] = k[0];
            for (int l = 0; l < 4; l++)
                exp_q[k][8*l +: 8] = ref_byte(bp_d[k][8*l +: 8], int'(bp_s[k]), bp_m[k], 1'b1);
        end
        do_reset();
        tx = 0; rx = 0; held = 1'b0; hold_d = '0;
        for (int cyc = 0; cyc < 80 && rx < 8; cyc++) begin
            out_ready = (cyc < 16) ? pattern[15 - cyc] : 1'b1;
            in_valid  = (tx < 8);
            if (tx < 8) begin
                in_data = bp_d[tx]; shift_amt = bp_s[tx]; mode = bp_m[tx]; in_lane_en = 4'hF;
            end
            #1;
            if (held) begin
                checks++;
                if (out_data !== hold_d) begin failures++; $display("FAIL bp_hold got=%h exp=%h", out_data, hold_d); end
            end
            held = out_valid && !out_ready;
            hold_d = out_data;
            if (out_valid && out_ready) begin
                checks++;
                if (out_data !== exp_q[rx]) begin failures++; $display("FAIL bp_beat%0d got=%h exp=%h", rx, out_data, exp_q[rx]); end
                rx++;
            end
            fire_in = in_valid && in_ready;
            @(posedge clk); #1;
            if (fire_in) tx++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (rx !== 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", rx); end
        checks++; if (beat_cnt !== 16'd8) begin failures++; $display("FAIL bp_beat_cnt got=%0d exp=8", beat_cnt); end
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            #1; if (out_valid) extra++;
            @(posedge clk); #1;
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL bp_duplicate got=%0d exp=0", extra); end
    endtask

`ifdef SHIFT_CIPHER_ROLLING_KEY_EN
    task automatic test_rolling_key();
        logic [31:0] q; int lat;
        do_reset();
        send_beat(32'h61616161, 4'hF, 5'd0, 1'b0, q, lat);
        checks++; if (q !== 32'h64636261) begin failures++; $display("FAIL roll_enc0 got=%h exp=64636261", q); end
        send_beat(32'h61616161, 4'hF, 5'd0, 1'b0, q, lat);
        checks++; if (q !== 32'h68676665) begin failures++; $display("FAIL roll_enc1 got=%h exp=68676665", q); end
        do_reset();
        send_beat(32'h64636261, 4'hF, 5'd0, 1'b1, q, lat);
        checks++; if (q !== 32'h61616161) begin failures++; $display("FAIL roll_dec0 got=%h exp=61616161", q); end
        send_beat(32'h68676665, 4'hF, 5'd0, 1'b1, q, lat);
        checks++; if (q !== 32'h61616161) begin failures++; $display("FAIL roll_dec1 got=%h exp=61616161", q); end
    endtask
`endif

    initial begin
        test_reset();
        test_midstream_reset();
`ifdef SHIFT_CIPHER_ROLLING_KEY_EN
        test_rolling_key();
`else
        test_encrypt();
        test_decrypt();
        test_key_boundary();
        test_lane_enable();
        test_back_to_back();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
